// File: rtl/irq_gateway.sv
// Interrupt gateway: synchronizes up to six peripheral requests, tracks each one
// through pending / in-service states and offers claim/complete over a small register bus.
module irq_gateway #(
    parameter int N_SRC       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_CLK,
    input  logic              i_RSTn,
    input  logic [N_SRC-1:0]  i_IRQ_SRC,
    input  logic              i_SEL,
    input  logic              i_WE,
    input  logic [4:0]        i_ADDR,
    input  logic [31:0]       i_WDATA,
    output logic [31:0]       o_RDATA,
    output logic              o_ACK,
    output logic              o_MEI_0,
    output logic              o_MEI_1,
    output logic              o_MEI_2,
    output logic              o_MEI_3,
    output logic              o_MEI_4,
    output logic              o_MEI_5
);

    localparam int MAX_SRC = 6;

    localparam logic [2:0] REG_PENDING   = 3'd0;
    localparam logic [2:0] REG_ENABLE    = 3'd1;
    localparam logic [2:0] REG_TRIGGER   = 3'd2;
    localparam logic [2:0] REG_CLAIM     = 3'd3;
    localparam logic [2:0] REG_COMPLETE  = 3'd4;
    localparam logic [2:0] REG_INSERVICE = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        PEND  = 3'b010,
        INSVC = 3'b100
    } src_state_t;

    logic [N_SRC-1:0]   sync_q [SYNC_STAGES];
    logic [N_SRC-1:0]   synced;
    logic [N_SRC-1:0]   prev_q;
    logic [N_SRC-1:0]   edge_evt;
    logic [N_SRC-1:0]   trig_evt;
    logic [N_SRC-1:0]   enable_q;
    logic [N_SRC-1:0]   enable_nxt;
    logic [N_SRC-1:0]   trigger_q;
    logic [N_SRC-1:0]   defer_q;
    logic [N_SRC-1:0]   defer_nxt;
    src_state_t         state_q   [N_SRC];
    src_state_t         state_nxt [N_SRC];
    logic [N_SRC-1:0]   pending_vec;
    logic [N_SRC-1:0]   insvc_vec;
    logic [N_SRC-1:0]   claim_onehot;
    logic [N_SRC-1:0]   complete_hit;
    logic [N_SRC-1:0]   mei_nxt;
    logic [N_SRC-1:0]   mei_q;
    logic [MAX_SRC-1:0] mei_all;
    logic [31:0]        claim_id;
    logic [31:0]        rdata_nxt;
    logic [2:0]         reg_sel;
    logic               rd_req;
    logic               wr_req;
    logic               claim_rd;
    logic               complete_wr;
    logic               unused_addr;

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= i_IRQ_SRC;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= synced;
        end
    end

    assign synced   = sync_q[SYNC_STAGES-1];
    assign edge_evt = synced & ~prev_q;
    assign trig_evt = (trigger_q & edge_evt) | (~trigger_q & synced);

    assign reg_sel     = i_ADDR[4:2];
    assign unused_addr = ^i_ADDR[1:0];
    assign rd_req      = i_SEL & ~i_WE;
    assign wr_req      = i_SEL & i_WE;
    assign claim_rd    = rd_req && (reg_sel == REG_CLAIM);
    assign complete_wr = wr_req && (reg_sel == REG_COMPLETE);

    // The interrupt line is registered from next-cycle state so it tracks the FSM with no extra lag.
    always_comb begin
        enable_nxt = enable_q;
        if (wr_req && (reg_sel == REG_ENABLE)) begin
            enable_nxt = i_WDATA[N_SRC-1:0];
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            enable_q  <= '0;
            trigger_q <= '0;
        end else begin
            enable_q <= enable_nxt;
            if (wr_req && (reg_sel == REG_TRIGGER)) begin
                trigger_q <= i_WDATA[N_SRC-1:0];
            end
        end
    end

    // Descending scan so the lowest enabled pending source wins.
    always_comb begin
        claim_onehot = '0;
        claim_id     = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (pending_vec[k] && enable_q[k]) begin
                claim_onehot    = '0;
                claim_onehot[k] = claim_rd;
                claim_id        = 32'(k + 1);
            end
        end
    end

    always_comb begin
        complete_hit = '0;
        for (int k = 0; k < N_SRC; k++) begin
            complete_hit[k] = complete_wr && (i_WDATA == 32'(k + 1));
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            for (int k = 0; k < N_SRC; k++) begin
                state_q[k] <= IDLE;
            end
            defer_q <= '0;
            mei_q   <= '0;
        end else begin
            for (int k = 0; k < N_SRC; k++) begin
                state_q[k] <= state_nxt[k];
            end
            defer_q <= defer_nxt;
            mei_q   <= mei_nxt;
        end
    end

    // An edge arriving while in service is remembered and re-pends the source on completion.
    always_comb begin
        defer_nxt = defer_q;
        for (int k = 0; k < N_SRC; k++) begin
            state_nxt[k] = state_q[k];
            case (state_q[k])
                IDLE: begin
                    if (trig_evt[k]) begin
                        state_nxt[k] = PEND;
                    end
                end
                PEND: begin
                    if (claim_onehot[k]) begin
                        state_nxt[k] = INSVC;
                    end
                end
                INSVC: begin
                    if (complete_hit[k]) begin
                        state_nxt[k] = (defer_q[k] || (trigger_q[k] && edge_evt[k])) ? PEND : IDLE;
                        defer_nxt[k] = 1'b0;
                    end else if (trigger_q[k] && edge_evt[k]) begin
                        defer_nxt[k] = 1'b1;
                    end
                end
                default: begin
                    state_nxt[k] = IDLE;
                    defer_nxt[k] = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pending_vec = '0;
        insvc_vec   = '0;
        mei_nxt     = '0;
        for (int k = 0; k < N_SRC; k++) begin
            pending_vec[k] = (state_q[k] == PEND);
            insvc_vec[k]   = (state_q[k] == INSVC);
            mei_nxt[k]     = (state_nxt[k] == PEND) && enable_nxt[k];
        end
    end

    always_comb begin
        rdata_nxt = '0;
        if (rd_req) begin
            case (reg_sel)
                REG_PENDING:   rdata_nxt = 32'(pending_vec);
                REG_ENABLE:    rdata_nxt = 32'(enable_q);
                REG_TRIGGER:   rdata_nxt = 32'(trigger_q);
                REG_CLAIM:     rdata_nxt = claim_id;
                REG_INSERVICE: rdata_nxt = 32'(insvc_vec);
                default:       rdata_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            o_ACK   <= 1'b0;
            o_RDATA <= '0;
        end else begin
            o_ACK   <= i_SEL;
            o_RDATA <= rdata_nxt;
        end
    end

    generate
        if (N_SRC < MAX_SRC) begin : g_pad
            assign mei_all = {{(MAX_SRC - N_SRC){1'b0}}, mei_q};
        end else begin : g_full
            assign mei_all = mei_q;
        end
    endgenerate

    assign o_MEI_0 = mei_all[0];
    assign o_MEI_1 = mei_all[1];
    assign o_MEI_2 = mei_all[2];
    assign o_MEI_3 = mei_all[3];
    assign o_MEI_4 = mei_all[4];
    assign o_MEI_5 = mei_all[5];

endmodule

// File: doc/irq_gateway.md
IRQ_GATEWAY -- requirements
Module: irq_gateway

Interface
REQ-001 SHALL have parameter N_SRC, default 6, number of interrupt sources (1..6).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth per source (>=2).
REQ-003 i_CLK  input  1  clock; all state on rising edge.
REQ-004 i_RSTn  input  1  reset, synchronous, active-low.
REQ-005 i_IRQ_SRC  input  N_SRC  asynchronous peripheral interrupt requests.
REQ-006 i_SEL  input  1  bus request valid, one transfer per asserted cycle.
REQ-007 i_WE  input  1  1=write, 0=read.
REQ-008 i_ADDR  input  5  byte offset; only [4:2] decoded.
REQ-009 i_WDATA  input  32  write data.
REQ-010 o_RDATA  output  32  registered read data, valid with o_ACK.
REQ-011 o_ACK  output  1  one-cycle acknowledge.
REQ-012 o_MEI_0..o_MEI_5  output  1 each  machine external interrupt lines to the core CSR unit; o_MEI_k for k>=N_SRC tied 0.

Function
REQ-013 SHALL register map: 0x00 PENDING RO; 0x04 ENABLE RW; 0x08 TRIGGER RW (1=edge, 0=level); 0x0C CLAIM RO with side effect; 0x10 COMPLETE WO; 0x14 INSERVICE RO; other offsets read 0, writes ignored.
REQ-014 SHALL pass each source through SYNC_STAGES flops; edge detect compares last sync stage with one further registered copy.
REQ-015 SHALL implement per-source FSM IDLE -> PEND -> INSVC -> IDLE; states one-hot-exclusive per source.
REQ-016 IDLE->PEND on trigger event: level mode = synced input 1; edge mode = synced 0->1 transition.
REQ-017 PEND SHALL persist regardless of input deassertion or ENABLE state until claimed.
REQ-018 CLAIM read SHALL return k+1 for the lowest index k in PEND with ENABLE[k]=1, else 0; the selected source moves PEND->INSVC on the same edge the read is accepted.
REQ-019 COMPLETE write of id k+1 with source k in INSVC SHALL move it to IDLE; id 0, id>N_SRC, or source not in INSVC SHALL be ignored.
REQ-020 Edge event while INSVC SHALL set a per-source deferred flag; on COMPLETE the source goes to PEND instead of IDLE and the flag clears; level sources return to IDLE and re-pend via REQ-016.
REQ-021 o_MEI_k SHALL be registered = (state_k==PEND) & ENABLE[k]; asserted on the 3rd rising edge after i_IRQ_SRC[k] rises (SYNC_STAGES=2, level, enabled), including the edge that first samples it.
REQ-022 o_ACK SHALL assert exactly one cycle after each cycle with i_SEL=1; back-to-back requests acked back-to-back.
REQ-023 o_RDATA SHALL be 0 in cycles where o_ACK=0.
REQ-024 PENDING/INSERVICE read bit k = state PEND / INSVC; bits >= N_SRC read 0; ENABLE/TRIGGER bits >= N_SRC not stored, read 0.
REQ-025 Trigger event and CLAIM in same cycle: CLAIM arbitrates on pre-edge state; a newly pending source is not claimable that cycle.
REQ-026 COMPLETE and new level event for same source in same cycle: source goes to IDLE, re-pends next cycle if input still high.
REQ-027 TRIGGER change SHALL not alter current state; it affects only future events.

Reset
REQ-028 On i_RSTn=0 at an edge: all FSMs IDLE, deferred flags 0, ENABLE=0, TRIGGER=0, sync flops 0, o_MEI_*=0, o_ACK=0, o_RDATA=0.
REQ-029 Reset mid-operation SHALL discard all pending and in-service state; no interrupt SHALL be produced in the cycle after reset release.

Verification
REQ-030 ENABLE=0x3F, TRIGGER=0, raise src2 -> o_MEI_2=1 on 3rd edge; CLAIM read returns 3, o_MEI_2=0 next cycle, INSERVICE=0x04.
REQ-031 src0 and src4 pending, both enabled -> CLAIM returns 1, then 5, then 0.
REQ-032 Edge mode src1: pulse, claim (returns 2), pulse again while INSVC, COMPLETE=2 -> PENDING=0x02, o_MEI_1=1.
REQ-033 COMPLETE=7, COMPLETE=0, COMPLETE=3 with src2 not INSVC -> no state change; INSERVICE unchanged.
REQ-034 ENABLE=0, src5 high -> PENDING=0x20, o_MEI_5=0, CLAIM returns 0; write ENABLE=0x20 -> o_MEI_5=1 next cycle.
REQ-035 src3 pending and INSVC on src0, assert i_RSTn=0 one cycle -> all outputs and registers 0; sources held high re-pend per REQ-021 timing.
